path_buf_lifo_fifo: RTL and testbench

//  Parametrised path buffer for the maze solver. Runs as a LIFO (STACK mode) while the solver

---
 rtl/path_buf_lifo_fifo.sv | 175 +++++++++++++++++
 tb/tb_path_buf_lifo_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/path_buf_lifo_fifo.sv
// path_buf_lifo_fifo
//   Path buffer for the maze solver.
//   STACK mode (mode=0): a LIFO that the solver pushes to while it explores and
//   pops from while it backtracks.
//   REPLAY mode (mode=1): a non-destructive FIFO read-out that starts at the
//   oldest entry, so the final path comes out start-to-goal. The solver can
//   return to STACK mode with the stored contents intact.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset; has priority over every other input
//   push          write data_in (STACK mode only; in REPLAY it is an error)
//   pop           STACK: remove the top entry; REPLAY: read the next-oldest entry
//   replay_start  pulse: enter REPLAY and restart the read-out at entry 0
//   stack_resume  pulse: return to STACK mode and keep the contents
//   data_in       entry to push
//   data_out      registered read data; holds its value while out_valid=0
//   out_valid     1-cycle strobe, high in the cycle data_out was updated
//   empty         STACK: count==0; REPLAY: every entry has been read out
//   full          count==DEPTH
//   count         number of stored entries, 0..DEPTH
//   mode          0=STACK, 1=REPLAY
//   overflow      sticky: push while full, or push in REPLAY mode
//   underflow     sticky: pop with nothing to read
module path_buf_lifo_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              replay_start,
   input  logic              stack_resume,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              empty,
   output logic              full,
   output logic [PTR_W:0]    count,
   output logic              mode,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [DATA_W-1:0] data_out_q,  data_out_d;
   logic              out_valid_q, out_valid_d;
   logic [PTR_W:0]    count_q,     count_d;
   logic [PTR_W:0]    rd_ptr_q,    rd_ptr_d;
   logic              mode_q,      mode_d;
   logic              overflow_q,  overflow_d;
   logic              underflow_q, underflow_d;

   logic              mem_we;
   logic [PTR_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [PTR_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [PTR_W-1:0]  top_idx;
   logic              is_empty;
   logic              is_full;

   // count-1 only matters when count>=1, so the low PTR_W bits are exact
   // (count==DEPTH maps to DEPTH-1).
   assign top_idx  = count_q[PTR_W-1:0] - IDX_ONE;
   assign is_full  = (count_q == FULL_CNT);
   assign is_empty = mode_q ? (rd_ptr_q == count_q) : (count_q == '0);
   assign rd_data  = mem_q[rd_addr];

   always_comb begin
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      mode_d      = mode_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      mem_we      = 1'b0;
      mem_waddr   = count_q[PTR_W-1:0];
      mem_wdata   = data_in;
      rd_addr     = top_idx;

      if (replay_start) begin
         mode_d   = 1'b1;
         rd_ptr_d = '0;
      end else if (stack_resume) begin
         mode_d = 1'b0;
      end else if (!mode_q) begin
         if (push && pop) begin
            if (!is_empty) begin
               // Replace the top: read the old value, overwrite in place.
               data_out_d  = rd_data;
               out_valid_d = 1'b1;
               mem_we      = 1'b1;
               mem_waddr   = top_idx;
            end else begin
               // Nothing to pop: behaves as a plain push (cannot be full here).
               mem_we      = 1'b1;
               count_d     = count_q + CNT_ONE;
               underflow_d = 1'b1;
            end
         end else if (push) begin
            if (!is_full) begin
               mem_we  = 1'b1;
               count_d = count_q + CNT_ONE;
            end else begin
               overflow_d = 1'b1;
            end
         end else if (pop) begin
            if (!is_empty) begin
               data_out_d  = rd_data;
               out_valid_d = 1'b1;
               count_d     = count_q - CNT_ONE;
            end else begin
               underflow_d = 1'b1;
            end
         end
      end else begin
         // Writes are illegal while replaying; a simultaneous pop is still served.
         if (push) overflow_d = 1'b1;
         if (pop) begin
            rd_addr = rd_ptr_q[PTR_W-1:0];
            if (!is_empty) begin
               data_out_d  = rd_data;
               out_valid_d = 1'b1;
               rd_ptr_d    = rd_ptr_q + CNT_ONE;
            end else begin
               underflow_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         mode_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         mode_q      <= mode_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; count=0 marks every entry invalid.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
   end

   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign count     = count_q;
   assign mode      = mode_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign empty     = is_empty;
   assign full      = is_full;

endmodule

// File: tb/tb_path_buf_lifo_fifo.sv
// Testbench for path_buf_lifo_fifo (DEPTH=4, DATA_W=8).
// Directed vector table, a reset-during-operation sequence, then randomized
// stimulus checked against a queue-based reference model.
module tb_path_buf_lifo_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int PTR_W  = 2;

   logic              clk;
   logic              rst, push, pop, replay_start, stack_resume;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              out_valid, empty, full, mode, overflow, underflow;
   logic [PTR_W:0]    count;

   int n_chk  = 0;
   int n_pass = 0;

   path_buf_lifo_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop),
      .replay_start(replay_start), .stack_resume(stack_resume),
      .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
      .empty(empty), .full(full), .count(count), .mode(mode),
      .overflow(overflow), .underflow(underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       r, pu, po, rs, sr;
      logic [7:0] din;
      logic [7:0] dout;
      logic       vld;
      int         cnt;
      logic       emp, ful, md, ov, un;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, pu, po, rs, sr, input logic [7:0] din,
                      input logic [7:0] dout, input logic vld, input int cnt,
                      input logic emp, ful, md, ov, un);
      vec_t v;
      v.r = r; v.pu = pu; v.po = po; v.rs = rs; v.sr = sr; v.din = din;
      v.dout = dout; v.vld = vld; v.cnt = cnt;
      v.emp = emp; v.ful = ful; v.md = md; v.ov = ov; v.un = un;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic check_all(input string tag, input logic [7:0] edout, input logic evld,
                            input int ecnt, input logic eemp, efull, emode, eov, eun);
      chk({tag, " data_out"},  int'(data_out),  int'(edout));
      chk({tag, " out_valid"}, int'(out_valid), int'(evld));
      chk({tag, " count"},     int'(count),     ecnt);
      chk({tag, " empty"},     int'(empty),     int'(eemp));
      chk({tag, " full"},      int'(full),      int'(efull));
      chk({tag, " mode"},      int'(mode),      int'(emode));
      chk({tag, " overflow"},  int'(overflow),  int'(eov));
      chk({tag, " underflow"}, int'(underflow), int'(eun));
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1ns later.
   task automatic apply(input logic r, pu, po, rs, sr, input logic [7:0] din);
      rst = r; push = pu; pop = po; replay_start = rs; stack_resume = sr; data_in = din;
      @(posedge clk);
      #1;
   endtask

   // Reference model: the stored path is a queue, oldest entry first.
   logic [7:0] m_q[$];
   int         m_rd;
   logic       m_mode, m_ov, m_un, m_vld;
   logic [7:0] m_dout;

   task automatic model_step(input logic r, pu, po, rs, sr, input logic [7:0] din);
      m_vld = 1'b0;
      if (r) begin
         m_q.delete(); m_rd = 0; m_mode = 1'b0; m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;
      end else if (rs) begin
         m_mode = 1'b1; m_rd = 0;
      end else if (sr) begin
         m_mode = 1'b0;
      end else if (!m_mode) begin
         if (pu && po) begin
            if (m_q.size() > 0) begin
               m_dout = m_q[m_q.size()-1];
               m_q[m_q.size()-1] = din;
               m_vld = 1'b1;
            end else begin
               m_q.push_back(din);
               m_un = 1'b1;
            end
         end else if (pu) begin
            if (m_q.size() < DEPTH) m_q.push_back(din);
            else m_ov = 1'b1;
         end else if (po) begin
            if (m_q.size() > 0) begin
               m_dout = m_q.pop_back();
               m_vld = 1'b1;
            end else m_un = 1'b1;
         end
      end else begin
         if (pu) m_ov = 1'b1;
         if (po) begin
            if (m_rd < m_q.size()) begin
               m_dout = m_q[m_rd];
               m_rd++;
               m_vld = 1'b1;
            end else m_un = 1'b1;
         end
      end
   endtask

   initial begin
      rst = 1'b0; push = 1'b0; pop = 1'b0; replay_start = 1'b0; stack_resume = 1'b0;
      data_in = '0;
      m_rd = 0; m_mode = 1'b0; m_ov = 1'b0; m_un = 1'b0; m_vld = 1'b0; m_dout = '0;

      //   r  pu po rs sr din     dout   vld cnt emp ful md ov un
      // LIFO push/pop ordering and latency
      add(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h11,  8'h00, 0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h22,  8'h00, 0, 2, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h33,  8'h00, 0, 3, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h33, 1, 2, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h22, 1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'h00,  8'h22, 0, 1, 0, 0, 0, 0, 0);
      // fill, overflow, replace-on-full
      add(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'hA0,  8'h00, 0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'hA1,  8'h00, 0, 2, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'hA2,  8'h00, 0, 3, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'hA3,  8'h00, 0, 4, 0, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'hFF,  8'h00, 0, 4, 0, 1, 0, 1, 0);
      add(0, 1, 1, 0, 0, 8'h55,  8'hA3, 1, 4, 0, 1, 0, 1, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h55, 1, 3, 0, 0, 0, 1, 0);
      // underflow on empty, cleared only by reset
      add(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h00, 0, 0, 1, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 0, 1, 0, 0, 0, 0);
      // replay read-out, exhaustion, restart
      add(0, 1, 0, 0, 0, 8'h12,  8'h00, 0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h34,  8'h00, 0, 2, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h56,  8'h00, 0, 3, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'h00,  8'h00, 0, 3, 0, 0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h12, 1, 3, 0, 0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h34, 1, 3, 0, 0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h56, 1, 3, 1, 0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 8'h00,  8'h56, 0, 3, 1, 0, 1, 0, 1);
      add(0, 0, 0, 1, 0, 8'h00,  8'h56, 0, 3, 0, 0, 1, 0, 1);
      add(0, 0, 1, 0, 0, 8'h00,  8'h12, 1, 3, 0, 0, 1, 0, 1);
      // push in replay, resume stack
      add(0, 1, 0, 0, 0, 8'h77,  8'h12, 0, 3, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 1, 8'h00,  8'h12, 0, 3, 0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 0, 8'h00,  8'h56, 1, 2, 0, 0, 0, 1, 1);
      // push+pop on empty stack; push+pop in replay
      add(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 8'h9A,  8'h00, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 8'h00,  8'h9A, 1, 0, 1, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 8'h01,  8'h9A, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0, 8'h00,  8'h9A, 0, 1, 0, 0, 1, 0, 1);
      add(0, 1, 1, 0, 0, 8'h02,  8'h01, 1, 1, 1, 0, 1, 1, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].r, tbl[i].pu, tbl[i].po, tbl[i].rs, tbl[i].sr, tbl[i].din);
         check_all($sformatf("row%0d", i), tbl[i].dout, tbl[i].vld, tbl[i].cnt,
                   tbl[i].emp, tbl[i].ful, tbl[i].md, tbl[i].ov, tbl[i].un);
      end

      // replay_start wins over push; reset drops a pending pop
      apply(1, 0, 0, 0, 0, 8'h00);
      apply(0, 1, 0, 0, 0, 8'h10);
      apply(0, 1, 0, 0, 0, 8'h20);
      apply(0, 1, 0, 1, 0, 8'h30);
      check_all("rs_push", 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(1, 0, 1, 0, 0, 8'h00);
      check_all("rst_pop", 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply(0, 0, 0, 0, 0, 8'h00);
      check_all("post_rst", 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // randomized run against the reference model
      apply(1, 0, 0, 0, 0, 8'h00);
      model_step(1, 0, 0, 0, 0, 8'h00);
      for (int c = 0; c < 3000; c++) begin
         logic r, pu, po, rs, sr;
         logic [7:0] din;
         int ecnt;
         r   = ($urandom_range(0, 99) < 2);
         rs  = ($urandom_range(0, 99) < 5);
         sr  = ($urandom_range(0, 99) < 6);
         pu  = ($urandom_range(0, 99) < 50);
         po  = ($urandom_range(0, 99) < 45);
         din = 8'($urandom);
         apply(r, pu, po, rs, sr, din);
         model_step(r, pu, po, rs, sr, din);
         ecnt = m_q.size();
         check_all($sformatf("rnd%0d", c), m_dout, m_vld, ecnt,
                   m_mode ? (m_rd == ecnt) : (ecnt == 0), ecnt == DEPTH,
                   m_mode, m_ov, m_un);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
